// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM state encoding,
// source index assignments and register reset values.
package trap_pkg;

  localparam int NSRC_MAX = 8;

  localparam int SRC_WDT = 0;
  localparam int SRC_DMA = 1;

  localparam logic [NSRC_MAX-1:0] EN_RST   = '0;
  localparam logic [NSRC_MAX-1:0] PEND_RST = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SAFE,
    ST_TAKE,
    ST_IN_ISR,
    ST_SLEEP
  } trap_state_e;

endpackage

// File: rtl/trap_sequencer_prio_enc.sv
// Fixed-priority encoder: the lowest set index of req wins.
module prio_enc #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] id
);

  // NOTE: every output gets a value before the loop, so no latch is inferred.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = W'(i);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Interrupt arbiter and trap-entry sequencer with wfi sleep and ISR tracking.
// Define TRAP_NEST_EN to allow one level of preemption by a higher-priority source.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic            en_we,
  input  logic [NSRC-1:0] en_wdata,
  output logic [NSRC-1:0] en_q,
  output logic [NSRC-1:0] pend_q,
  input  logic            gie,
  input  logic            im_stall,
  input  logic            dm_stall,
  input  logic            wfi_ret,
  input  logic            mret_ret,
  output logic            trap_take,
  output logic            trap_flush,
  output logic [IDW-1:0]  irq_id,
  output logic            cpu_halt,
  output logic            in_isr,
  output logic            trap_done
);

  trap_state_e     state;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] elig;
  logic            win_valid;
  logic [IDW-1:0]  win_id;
  logic            stall;

`ifdef TRAP_NEST_EN
  logic            nested;
  logic [IDW-1:0]  stk_id;
`endif

  assign stall = im_stall | dm_stall;
  assign rise  = src_irq & ~src_q;
  assign elig  = pend_q & en_q;
  // trap_take is high exactly in the TAKE cycle, when irq_id holds the taken source.
  assign clr_mask = trap_take ? (NSRC'(1) << irq_id) : '0;

  prio_enc #(.N(NSRC), .W(IDW)) u_prio (
    .req   (elig),
    .valid (win_valid),
    .id    (win_id)
  );

  // Clear is applied before set so a fresh edge in the TAKE cycle survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q  <= '0;
      pend_q <= PEND_RST[NSRC-1:0];
      en_q   <= EN_RST[NSRC-1:0];
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      src_q  <= src_irq;
      pend_q <= (pend_q & ~clr_mask) | rise;
      if (en_we) en_q <= en_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      trap_take  <= 1'b0;
      trap_flush <= 1'b0;
      trap_done  <= 1'b0;
      irq_id     <= '0;
      cpu_halt   <= 1'b0;
      in_isr     <= 1'b0;
`ifdef TRAP_NEST_EN
      nested     <= 1'b0;
      stk_id     <= '0;
`endif
    end else begin
      trap_take  <= 1'b0;
      trap_flush <= 1'b0;
      trap_done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (win_valid && gie) begin
            state <= ST_WAIT_SAFE;
          end else if (wfi_ret && !stall && !win_valid) begin
            state    <= ST_SLEEP;
            cpu_halt <= 1'b1;
          end
        end
        ST_WAIT_SAFE: begin
          // in_isr is only high here while waiting to preempt an active ISR.
          if (!win_valid || !gie || (in_isr && win_id >= irq_id)) begin
            state <= in_isr ? ST_IN_ISR : ST_IDLE;
          end else if (!stall) begin
            state      <= ST_TAKE;
            trap_take  <= 1'b1;
            trap_flush <= 1'b1;
            irq_id     <= win_id;
`ifdef TRAP_NEST_EN
            if (in_isr) begin
              nested <= 1'b1;
              stk_id <= irq_id;
            end
`endif
          end
        end
        ST_TAKE: begin
          state  <= ST_IN_ISR;
          in_isr <= 1'b1;
        end
        ST_IN_ISR: begin
          if (mret_ret && !stall) begin
            trap_done <= 1'b1;
`ifdef TRAP_NEST_EN
            if (nested) begin
              nested <= 1'b0;
              irq_id <= stk_id;
            end else begin
              state  <= ST_IDLE;
              in_isr <= 1'b0;
              irq_id <= '0;
            end
`else
            state  <= ST_IDLE;
            in_isr <= 1'b0;
            irq_id <= '0;
`endif
          end
`ifdef TRAP_NEST_EN
          else if (!nested && gie && win_valid && win_id < irq_id) begin
            state <= ST_WAIT_SAFE;
          end
`endif
        end
        ST_SLEEP: begin
          if (win_valid) begin
            cpu_halt <= 1'b0;
            state    <= gie ? ST_WAIT_SAFE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_trap_sequencer;

  localparam int NSRC = 4;
  localparam int IDW  = 3;
`ifdef TRAP_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSRC-1:0] src_irq = '0;
  logic            en_we = 1'b0;
  logic [NSRC-1:0] en_wdata = '0;
  logic [NSRC-1:0] en_q;
  logic [NSRC-1:0] pend_q;
  logic            gie = 1'b0;
  logic            im_stall = 1'b0;
  logic            dm_stall = 1'b0;
  logic            wfi_ret = 1'b0;
  logic            mret_ret = 1'b0;
  logic            trap_take;
  logic            trap_flush;
  logic [IDW-1:0]  irq_id;
  logic            cpu_halt;
  logic            in_isr;
  logic            trap_done;

  trap_sequencer #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .en_we      (en_we),
    .en_wdata   (en_wdata),
    .en_q       (en_q),
    .pend_q     (pend_q),
    .gie        (gie),
    .im_stall   (im_stall),
    .dm_stall   (dm_stall),
    .wfi_ret    (wfi_ret),
    .mret_ret   (mret_ret),
    .trap_take  (trap_take),
    .trap_flush (trap_flush),
    .irq_id     (irq_id),
    .cpu_halt   (cpu_halt),
    .in_isr     (in_isr),
    .trap_done  (trap_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the ISR nesting is a stack of active IDs.
  typedef enum {M_RUN, M_ARM, M_FIRE, M_SLEEP} mphase_e;
  mphase_e         m_phase;
  bit [NSRC-1:0]   m_pend;
  bit [NSRC-1:0]   m_en;
  bit [NSRC-1:0]   m_src;
  int              m_stack[$];
  int              m_fire;
  bit              m_done;

  function automatic int lowest(input bit [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = M_RUN;
    m_pend  = '0;
    m_en    = '0;
    m_src   = '0;
    m_stack.delete();
    m_fire  = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    bit [NSRC-1:0] rise;
    int            w;
    bit            stl;
    rise   = src_irq & ~m_src;
    w      = lowest(m_pend & m_en);
    stl    = im_stall | dm_stall;
    m_done = 1'b0;
    case (m_phase)
      M_RUN: begin
        if (m_stack.size() == 0) begin
          if (w >= 0 && gie) m_phase = M_ARM;
          else if (wfi_ret && !stl && w < 0) m_phase = M_SLEEP;
        end else if (mret_ret && !stl) begin
          void'(m_stack.pop_back());
          m_done = 1'b1;
        end else if (NEST && gie && m_stack.size() == 1 && w >= 0 && w < m_stack[0]) begin
          m_phase = M_ARM;
        end
      end
      M_ARM: begin
        if (w < 0 || !gie || (m_stack.size() > 0 && w >= m_stack[$])) m_phase = M_RUN;
        else if (!stl) begin
          m_phase = M_FIRE;
          m_fire  = w;
        end
      end
      M_FIRE: begin
        m_pend[m_fire] = 1'b0;
        m_stack.push_back(m_fire);
        m_phase = M_RUN;
      end
      M_SLEEP: if (w >= 0) m_phase = gie ? M_ARM : M_RUN;
      default: m_phase = M_RUN;
    endcase
    m_pend = m_pend | rise;
    m_src  = src_irq;
    if (en_we) m_en = en_wdata;
  endtask

  task automatic compare_all();
    int exp_id;
    exp_id = 0;
    if (m_phase == M_FIRE) exp_id = m_fire;
    else if (m_stack.size() > 0) exp_id = m_stack[$];
    check("en_q", en_q, m_en);
    check("pend_q", pend_q, m_pend);
    check("trap_take", trap_take, m_phase == M_FIRE);
    check("trap_flush", trap_flush, m_phase == M_FIRE);
    check("irq_id", irq_id, exp_id);
    check("cpu_halt", cpu_halt, m_phase == M_SLEEP);
    check("in_isr", in_isr, m_stack.size() > 0);
    check("trap_done", trap_done, m_done);
  endtask

  // Inputs are set at the falling edge; the model steps at the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Drain any pending work by acknowledging every ISR immediately.
  task automatic settle();
    src_irq  = '0;
    gie      = 1'b1;
    mret_ret = 1'b1;
    cycles(10);
    mret_ret = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_pend", pend_q, 0);
    rst = 1'b1;

    // Basic trap entry
    en_we = 1'b1; en_wdata = 4'b0010; gie = 1'b1;
    cycle();
    check("basic_en", en_q, 4'b0010);
    en_we = 1'b0; src_irq = 4'b0010;
    cycle();
    check("basic_pend_set", pend_q, 4'b0010);
    cycle();
    check("basic_no_take_yet", trap_take, 0);
    cycle();
    check("basic_take", trap_take, 1);
    check("basic_flush", trap_flush, 1);
    check("basic_id", irq_id, 1);
    cycle();
    check("basic_pend_clr", pend_q, 0);
    check("basic_in_isr", in_isr, 1);
    mret_ret = 1'b1;
    cycle();
    check("basic_done", trap_done, 1);
    check("basic_isr_exit", in_isr, 0);
    mret_ret = 1'b0; src_irq = '0;

    // Priority between simultaneous rises
    en_we = 1'b1; en_wdata = 4'b1111;
    cycle();
    en_we = 1'b0; src_irq = 4'b0011;
    cycles(3);
    check("prio_first_take", trap_take, 1);
    check("prio_first_id", irq_id, 0);
    src_irq = '0;
    cycle();
    mret_ret = 1'b1;
    cycle();
    mret_ret = 1'b0;
    cycles(2);
    check("prio_second_take", trap_take, 1);
    check("prio_second_id", irq_id, 1);
    cycle();
    mret_ret = 1'b1;
    cycle();
    mret_ret = 1'b0;

    // Stall hold
    dm_stall = 1'b1; src_irq = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_no_take", trap_take, 0);
    end
    dm_stall = 1'b0;
    cycle();
    check("stall_take_after", trap_take, 1);
    check("stall_id", irq_id, 2);
    settle();

    // WFI wake with gie = 0
    gie = 1'b0; wfi_ret = 1'b1;
    cycle();
    check("wfi_halt", cpu_halt, 1);
    wfi_ret = 1'b0; src_irq = 4'b0010;
    cycle();
    check("wfi_still_halt", cpu_halt, 1);
    cycle();
    check("wfi_wake", cpu_halt, 0);
    check("wfi_no_take", trap_take, 0);
    cycle();
    check("wfi_idle_no_take", trap_take, 0);
    check("wfi_idle_no_isr", in_isr, 0);
    settle();

    // Set/clear collision in the TAKE cycle
    src_irq = 4'b1000;
    cycle();
    src_irq = '0;
    cycles(2);
    check("coll_take", trap_take, 1);
    check("coll_id", irq_id, 3);
    src_irq = 4'b1000;
    cycle();
    check("coll_pend_kept", pend_q[3], 1);
    settle();

`ifdef TRAP_NEST_EN
    // One level of preemption
    src_irq = 4'b0100;
    cycles(4);
    check("nest_outer_id", irq_id, 2);
    check("nest_outer_isr", in_isr, 1);
    src_irq = 4'b0101;
    cycles(3);
    check("nest_inner_take", trap_take, 1);
    check("nest_inner_id", irq_id, 0);
    cycle();
    mret_ret = 1'b1;
    cycle();
    check("nest_pop_done", trap_done, 1);
    check("nest_pop_id", irq_id, 2);
    check("nest_pop_isr", in_isr, 1);
    cycle();
    check("nest_exit_done", trap_done, 1);
    check("nest_exit_isr", in_isr, 0);
    mret_ret = 1'b0;
    settle();
`endif

    // Reset asserted mid-ISR aborts without trap_done
    src_irq = 4'b0001;
    cycles(4);
    check("abort_pre_isr", in_isr, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_isr", in_isr, 0);
    check("abort_id", irq_id, 0);
    check("abort_done", trap_done, 0);
    check("abort_en", en_q, 0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    src_irq = '0;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      src_irq  = src_irq ^ (($urandom_range(0, 3) == 0) ? NSRC'($urandom) : NSRC'(0));
      en_we    = ($urandom_range(0, 7) == 0);
      en_wdata = NSRC'($urandom);
      gie      = ($urandom_range(0, 6) != 0);
      im_stall = ($urandom_range(0, 4) == 0);
      dm_stall = ($urandom_range(0, 4) == 0);
      wfi_ret  = ($urandom_range(0, 9) == 0);
      mret_ret = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Interrupt arbiter and trap-entry sequencer between the interrupt sources (DMA done, WDT timeout, spares) and the CPU's CSR unit and pipeline. It latches source edges into pending bits, selects the highest-priority enabled request, waits for a stall-free cycle, then issues a one-cycle trap-take with flush and redirect. It also holds the core in `wfi` sleep until a wake-up event and tracks ISR occupancy until `mret` retires.

## Interface
Parameters:
- `NSRC`, default 4: number of interrupt sources, 2..8. Index 0 is the highest priority.
- `IDW`, default 3: width of `irq_id`. Must satisfy $clog2(NSRC) ≤ IDW.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `src_irq`  in  NSRC  level source lines (bit 0 = WDT, bit 1 = DMA)
- `en_we`  in  1  write strobe for the enable register
- `en_wdata`  in  NSRC  new enable mask
- `en_q`  out  NSRC  current enable mask
- `pend_q`  out  NSRC  current pending bits
- `gie`  in  1  global interrupt enable (mstatus.MIE)
- `im_stall`, `dm_stall`  in  1 each  memory stalls
- `wfi_ret`  in  1  a `wfi` is retiring this cycle
- `mret_ret`  in  1  an `mret` is retiring this cycle
- `trap_take`  out  1  one-cycle trap-entry pulse to the CSR unit
- `trap_flush`  out  1  pipeline flush, coincident with `trap_take`
- `irq_id`  out  IDW  ID of the taken or active source; 0 when idle
- `cpu_halt`  out  1  core held in `wfi` sleep
- `in_isr`  out  1  an ISR is active
- `trap_done`  out  1  one-cycle pulse when `mret` closes the ISR

## Operation
**Edge detection and pending bits**
- Registered copy `src_q`. rise = `src_irq & ~src_q`.
- A pending bit sets on rise and clears on the take of that ID.
- If set and clear coincide for the same bit, set wins.

**Enable register**
- Written whenever `en_we` is high.
- Eligible vector = `pend_q & en_q`.

**Priority**
- The lowest set index of the eligible vector wins. This is a fixed priority encoder.

**FSM states:** IDLE, WAIT_SAFE, TAKE, IN_ISR, SLEEP.
- IDLE → WAIT_SAFE when eligible ≠ 0 and `gie` = 1.
- IDLE → SLEEP when `wfi_ret`, no stall, and eligible = 0.
- If `wfi_ret` arrives while eligible ≠ 0, the FSM does not enter SLEEP. It follows the IDLE rules above.
- WAIT_SAFE → TAKE on the first cycle with `~im_stall & ~dm_stall`. The winner ID is captured in that cycle.
- WAIT_SAFE → IDLE if eligible drops to 0 or `gie` drops to 0.
- TAKE lasts 1 cycle: `trap_take` = `trap_flush` = 1, `irq_id` = captured ID, and that pending bit clears. Next state is IN_ISR.
- IN_ISR: `in_isr` = 1 and `irq_id` holds. On `mret_ret` with no stall: `trap_done` pulses and the FSM goes to IDLE.
- SLEEP: `cpu_halt` = 1. Wake when eligible ≠ 0, regardless of `gie`. Go to WAIT_SAFE if `gie` = 1, else to IDLE (execution resumes after the `wfi`).
- An `mret_ret` seen outside IN_ISR is ignored.
- Simultaneous events: `mret_ret` and a new eligible source in the same cycle cause IN_ISR → IDLE. WAIT_SAFE follows on the next cycle.

## Timing
**Reset values:** all outputs 0. FSM = IDLE. `src_q`, pending and enable registers all 0.
- Reset asserted mid-trap aborts immediately. No `trap_done` is issued.

**Latencies**
- `src_irq` rise to pend bit set: 1 cycle.
- Pend bit set to `trap_take`, best case: 2 cycles (IDLE → WAIT_SAFE → TAKE).
- SLEEP wake to `cpu_halt` low: 1 cycle.
- `en_q` and `pend_q` update 1 cycle after the causing event.

**Pulse widths:** all pulses are exactly 1 cycle wide, and `trap_take` never asserts while a stall input is high.

## Configuration
Macro `TRAP_NEST_EN`.

**When defined:** one level of preemption is supported.
- In IN_ISR with `gie` = 1, an eligible source with index strictly below the active ID triggers WAIT_SAFE → TAKE.
- The active ID is pushed to a 1-entry stack, and depth becomes 2.
- `mret` at depth 2 pops the stack, restores `irq_id`, returns to IN_ISR, and pulses `trap_done`.
- No preemption occurs at depth 2.

**When undefined:** IN_ISR never takes a new trap, and the stack logic is absent.

## Structure
**Package `trap_pkg`:**
- `trap_state_e` enum.
- `NSRC_MAX` = 8.
- Source index constants `SRC_WDT` = 0 and `SRC_DMA` = 1.
- Reset constants for the enable and pending registers.

**Sub-module `prio_enc`:** parameterised lowest-index-first priority encoder. Outputs `valid` and `id`. It is shared by the arbitration path and the preemption check.

## Test plan
- **Basic trap entry:** `en_q` = 4'b0010, `gie` = 1, rise on `src_irq[1]` → `pend_q[1]` = 1 next cycle; `trap_take`/`trap_flush` pulse 2 cycles later with `irq_id` = 1; `pend_q[1]` clears; `in_isr` = 1.
- **Priority:** rises on bits 1 and 0 in the same cycle, all enabled → first take has `irq_id` = 0; after `mret_ret`, second take has `irq_id` = 1.
- **Stall hold:** pending eligible while `dm_stall` is high for 5 cycles → `trap_take` stays 0 and asserts in the first cycle after the stall drops.
- **WFI wake with `gie` = 0:** `wfi_ret` with eligible = 0 → `cpu_halt` = 1; rise on bit 1 → `cpu_halt` drops, no `trap_take`, FSM returns to IDLE.
- **Set/clear collision:** a new rise on the source in its own TAKE cycle → `pend_q` bit remains 1 after TAKE.
- **Nesting (`TRAP_NEST_EN`):** in the ISR for ID 2 with `gie` = 1, rise on bit 0 → take with `irq_id` = 0; first `mret` restores `irq_id` = 2 and keeps `in_isr` = 1; second `mret` returns to IDLE.
